// File: rtl/mips_shift_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM state encoding
// and a bit-reversal helper used to turn the left-only shifter into a right shifter.
package mips_shift_pkg;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   function automatic logic [31:0] rev32(input logic [31:0] d);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = d[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_sequencer_bit_rev32.sv
// 32-bit bit reversal: a pure wire permutation with no logic.
module bit_rev32
   import mips_shift_pkg::*;
(
   input  logic [31:0] d_i,
   output logic [31:0] d_o
);

   assign d_o = rev32(d_i);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle controller driving an external 32-bit left-only barrel shifter
// to implement SLL/SRL/SRA/ROTR in one or two passes.
module shift_sequencer
   import mips_shift_pkg::*;
#(
   parameter bit ZERO_SKIP = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_data,
   input  logic [4:0]  req_amt,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        busy,
   output logic [31:0] sh_a,
   output logic [5:0]  sh_b,
   input  logic [31:0] sh_out
);

   state_e      state_q;
   logic [1:0]  op_q;
   logic [31:0] x_q;
   logic [4:0]  n_q;
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic        resp_valid_q;
   logic [31:0] x_rev_s;
   logic [31:0] out_rev_s;

   bit_rev32 u_rev_a   (.d_i(x_q),    .d_o(x_rev_s));
   bit_rev32 u_rev_out (.d_i(sh_out), .d_o(out_rev_s));

   assign req_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_data  = acc_q;

   // Right shifts reverse the operand, shift left, and reverse back; the second
   // pass fills the vacated top bits (sign fill for SRA, wrapped bits for ROTR).
   always_comb begin
      sh_a = 32'd0;
      sh_b = 6'd0;
      case (state_q)
         ST_PASS1: begin
            sh_b = {1'b0, n_q};
            if (op_q == OP_SLL) begin
               sh_a = x_q;
            end else begin
               sh_a = x_rev_s;
            end
         end
         ST_PASS2: begin
            sh_b = 6'd32 - {1'b0, n_q};
            if (op_q == OP_SRA) begin
               sh_a = 32'hFFFF_FFFF;
            end else begin
               sh_a = x_q;
            end
         end
         default: begin
            sh_a = 32'd0;
            sh_b = 6'd0;
         end
      endcase
   end

   // Accumulator update for each shifter pass.
   always_comb begin
      acc_d = acc_q;
      case (state_q)
         ST_PASS1: begin
            if (op_q == OP_SLL) begin
               acc_d = sh_out;
            end else begin
               acc_d = out_rev_s;
            end
         end
         ST_PASS2: begin
            if (op_q == OP_SRA) begin
               acc_d = acc_q | (x_q[31] ? sh_out : 32'd0);
            end else begin
               acc_d = acc_q | sh_out;
            end
         end
         default: acc_d = acc_q;
      endcase
   end

   // Sequencer FSM, operand latches, accumulator and response flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= 2'b00;
         x_q          <= 32'd0;
         n_q          <= 5'd0;
         acc_q        <= 32'd0;
         resp_valid_q <= 1'b0;
      end else if (flush) begin
         state_q      <= ST_IDLE;
         resp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q <= req_op;
                  x_q  <= req_data;
                  n_q  <= req_amt;
                  if (ZERO_SKIP && (req_amt == 5'd0)) begin
                     acc_q        <= req_data;
                     state_q      <= ST_DONE;
                     resp_valid_q <= 1'b1;
                  end else begin
                     state_q <= ST_PASS1;
                  end
               end
            end
            ST_PASS1: begin
               acc_q <= acc_d;
               if ((op_q == OP_SLL) || (op_q == OP_SRL)) begin
                  state_q      <= ST_DONE;
                  resp_valid_q <= 1'b1;
               end else begin
                  state_q <= ST_PASS2;
               end
            end
            ST_PASS2: begin
               acc_q        <= acc_d;
               state_q      <= ST_DONE;
               resp_valid_q <= 1'b1;
            end
            ST_DONE: begin
               if (resp_ready) begin
                  state_q      <= ST_IDLE;
                  resp_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               resp_valid_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
